// File: rtl/reg_port_ctrl.sv
// Initiator for a single-port 32x32 register file: serialises write-back and
// two-operand fetches into one file access per clock, with x0 reading as zero.
module reg_port_ctrl #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input  logic              clkout,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_rs1,
   input  logic [ADDR_W-1:0] req_rs2,
   output logic              op_valid,
   input  logic              op_ready,
   output logic [DATA_W-1:0] op_a,
   output logic [DATA_W-1:0] op_b,
   input  logic              wb_valid,
   output logic              wb_ready,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic              rf_sal,
   output logic [ADDR_W-1:0] rf_addr,
   output logic [DATA_W-1:0] rf_wdata,
   input  logic [DATA_W-1:0] rf_rdata
);

   typedef enum logic [2:0] {IDLE, WR, RA, RB, CB, RSP} state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] rs1;
      logic [ADDR_W-1:0] rs2;
   } fetch_t;

   state_t state, state_nxt;
   fetch_t fetch_q;
   logic   wr_go, rd_go;

   // Write-back wins over fetch; an x0 write is acknowledged but never issued.
   assign wb_ready  = (state == IDLE);
   assign req_ready = (state == IDLE) && !wb_valid;
   assign wr_go     = wb_ready && wb_valid && (wb_addr != '0);
   assign rd_go     = req_ready && req_valid;

   always_ff @(posedge clkout or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (wr_go) state_nxt = WR;
                  else if (rd_go) state_nxt = RA;
         WR:      state_nxt = IDLE;
         RA:      state_nxt = RB;
         RB:      state_nxt = CB;
         CB:      state_nxt = RSP;
         RSP:     if (op_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // rf_addr leads the data by one edge: rs1 is presented in RA, its data
   // arrives in RB while rs2 is being presented, and rs2's data arrives in CB.
   always_ff @(posedge clkout or negedge rst_n) begin
      if (!rst_n) begin
         fetch_q  <= '0;
         rf_sal   <= 1'b0;
         rf_addr  <= '0;
         rf_wdata <= '0;
         op_a     <= '0;
         op_b     <= '0;
         op_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (wr_go) begin
                  rf_sal   <= 1'b1;
                  rf_addr  <= wb_addr;
                  rf_wdata <= wb_data;
               end else if (rd_go) begin
                  fetch_q.rs1 <= req_rs1;
                  fetch_q.rs2 <= req_rs2;
                  rf_addr     <= req_rs1;
               end
            end
            WR: rf_sal <= 1'b0;
            RA: rf_addr <= fetch_q.rs2;
            RB: op_a <= (fetch_q.rs1 == '0) ? '0 : rf_rdata;
            CB: begin
               op_b     <= (fetch_q.rs2 == '0) ? '0 : rf_rdata;
               op_valid <= 1'b1;
            end
            RSP: if (op_ready) op_valid <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_reg_port_ctrl.sv
// Directed bench for reg_port_ctrl with a behavioural single-port register file.
module tb_reg_port_ctrl;
   localparam int AW = 5;
   localparam int DW = 32;

   logic          clkout = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0, req_ready;
   logic [AW-1:0] req_rs1 = '0, req_rs2 = '0;
   logic          op_valid, op_ready = 1'b0;
   logic [DW-1:0] op_a, op_b;
   logic          wb_valid = 1'b0, wb_ready;
   logic [AW-1:0] wb_addr = '0;
   logic [DW-1:0] wb_data = '0;
   logic          rf_sal;
   logic [AW-1:0] rf_addr;
   logic [DW-1:0] rf_wdata;
   logic [DW-1:0] rf_rdata = '0;

   int total = 0, bad = 0;
   int cyc = 0, sal_cnt = 0, vpulse = 0;
   logic [AW-1:0] sal_addr = '0;
   logic ov_q = 1'b0;
   // Unwritten entries (including x0) hold non-zero junk.
   logic [DW-1:0] mem [32] = '{default: 32'hBAD0_0BAD};

   reg_port_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clkout(clkout), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_rs1(req_rs1), .req_rs2(req_rs2),
      .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
      .rf_sal(rf_sal), .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
   );

   always #5 clkout = ~clkout;

   // Register file: write when Sal=1, registered read data one edge later.
   always @(posedge clkout) begin
      cyc <= cyc + 1;
      if (rf_sal) begin
         mem[rf_addr] <= rf_wdata;
         sal_cnt      <= sal_cnt + 1;
         sal_addr     <= rf_addr;
      end
      rf_rdata <= mem[rf_addr];
      ov_q     <= op_valid;
      if (op_valid && !ov_q) vpulse <= vpulse + 1;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Both tasks start and end at a falling edge.
   task automatic do_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, output int acc);
      int n = 0;
      wb_valid = 1'b1; wb_addr = a; wb_data = d; #1;
      while (!wb_ready && n < 50) begin @(negedge clkout); #1; n++; end
      chk("wr_accept_timeout", 32'(n < 50), 1);
      @(posedge clkout); #1 acc = cyc;
      @(negedge clkout); wb_valid = 1'b0;
   endtask

   task automatic do_rd(input logic [AW-1:0] r1, input logic [AW-1:0] r2, input bit rdy,
                        output logic [DW-1:0] a, output logic [DW-1:0] b,
                        output int acc, output int lat);
      int n = 0;
      op_ready = rdy; req_valid = 1'b1; req_rs1 = r1; req_rs2 = r2; #1;
      while (!req_ready && n < 50) begin @(negedge clkout); #1; n++; end
      chk("rd_accept_timeout", 32'(n < 50), 1);
      @(posedge clkout); #1 acc = cyc;
      @(negedge clkout); req_valid = 1'b0;
      n = 0;
      while (!op_valid && n < 50) begin @(negedge clkout); n++; end
      chk("op_valid_timeout", 32'(n < 50), 1);
      lat = cyc - acc;
      a = op_a; b = op_b;
   endtask

   typedef struct {
      bit            wr;
      logic [AW-1:0] a1;
      logic [AW-1:0] a2;
      logic [DW-1:0] d;
      logic [DW-1:0] ea;
      logic [DW-1:0] eb;
   } vec_t;

   vec_t tbl [9];

   initial begin
      logic [DW-1:0] a, b, a0, b0, val;
      int w, f, lat, s0, p0, pw, pf, gapbad;

      tbl[0] = '{1'b1, 5'd7,  5'd0,  32'hA5A5A5A5, 32'h0,        32'h0};
      tbl[1] = '{1'b1, 5'd0,  5'd0,  32'h00001234, 32'h0,        32'h0};
      tbl[2] = '{1'b0, 5'd0,  5'd7,  32'h0,        32'h0,        32'hA5A5A5A5};
      tbl[3] = '{1'b1, 5'd4,  5'd0,  32'hCAFEF00D, 32'h0,        32'h0};
      tbl[4] = '{1'b0, 5'd7,  5'd4,  32'h0,        32'hA5A5A5A5, 32'hCAFEF00D};
      tbl[5] = '{1'b0, 5'd0,  5'd0,  32'h0,        32'h0,        32'h0};
      tbl[6] = '{1'b0, 5'd4,  5'd0,  32'h0,        32'hCAFEF00D, 32'h0};
      tbl[7] = '{1'b1, 5'd31, 5'd0,  32'hFFFFFFFF, 32'h0,        32'h0};
      tbl[8] = '{1'b0, 5'd31, 5'd5,  32'h0,        32'hFFFFFFFF, 32'hDEADBEEF};

      // Reset state
      repeat (2) @(negedge clkout);
      #1;
      chk("rst_op_valid", op_valid, 0);
      chk("rst_rf_sal", rf_sal, 0);
      chk("rst_wb_ready", wb_ready, 1);
      chk("rst_req_ready", req_ready, 1);
      wb_valid = 1'b1; #1;
      chk("rst_req_ready_wb", req_ready, 0);
      wb_valid = 1'b0;
      @(negedge clkout); rst_n = 1'b1;
      @(negedge clkout);

      // Write r5 then fetch (5,5) two edges after the write
      s0 = sal_cnt;
      do_wr(5, 32'hDEADBEEF, w);
      do_rd(5, 5, 1'b1, a, b, f, lat);
      chk("wr_to_rd_gap", f - w, 2);
      chk("rd_latency", lat, 3);
      chk("r5_op_a", a, 32'hDEADBEEF);
      chk("r5_op_b", b, 32'hDEADBEEF);
      chk("r5_sal_count", sal_cnt - s0, 1);
      chk("r5_sal_addr", sal_addr, 5);
      @(negedge clkout);
      chk("op_valid_one_cycle", op_valid, 0);

      // Value table; x0 writes must never raise rf_sal
      for (int i = 0; i < 9; i++) begin
         if (tbl[i].wr) begin
            s0 = sal_cnt;
            do_wr(tbl[i].a1, tbl[i].d, w);
            @(negedge clkout);
            chk($sformatf("tbl%0d_sal_count", i), sal_cnt - s0, (tbl[i].a1 != 0) ? 1 : 0);
         end else begin
            do_rd(tbl[i].a1, tbl[i].a2, 1'b1, a, b, f, lat);
            chk($sformatf("tbl%0d_op_a", i), a, tbl[i].ea);
            chk($sformatf("tbl%0d_op_b", i), b, tbl[i].eb);
            chk($sformatf("tbl%0d_lat", i), lat, 3);
            @(negedge clkout);
         end
      end

      // Simultaneous write-back and fetch: write goes first
      wb_valid = 1'b1; wb_addr = 3; wb_data = 32'h11;
      req_valid = 1'b1; req_rs1 = 3; req_rs2 = 4; op_ready = 1'b1; #1;
      chk("both_wb_ready", wb_ready, 1);
      chk("both_req_ready", req_ready, 0);
      @(posedge clkout); #1 w = cyc;
      @(negedge clkout); wb_valid = 1'b0;
      do_rd(3, 4, 1'b1, a, b, f, lat);
      chk("both_rd_gap", f - w, 2);
      chk("both_op_a", a, 32'h11);
      chk("both_op_b", b, 32'hCAFEF00D);
      @(negedge clkout);

      // Consumer stalls for 5 cycles
      do_rd(7, 31, 1'b0, a0, b0, f, lat);
      chk("stall_op_a", a0, 32'hA5A5A5A5);
      chk("stall_op_b", b0, 32'hFFFFFFFF);
      for (int i = 0; i < 5; i++) begin
         @(negedge clkout);
         chk("stall_op_valid", op_valid, 1);
         chk("stall_op_a_hold", op_a, a0);
         chk("stall_op_b_hold", op_b, b0);
         chk("stall_req_ready", req_ready, 0);
         chk("stall_wb_ready", wb_ready, 0);
      end
      op_ready = 1'b1;
      @(negedge clkout);
      chk("stall_release_valid", op_valid, 0);
      chk("stall_release_idle", wb_ready, 1);

      // Asynchronous reset while in RB
      p0 = vpulse;
      req_valid = 1'b1; req_rs1 = 5; req_rs2 = 31; #1;
      chk("rstrb_accept", req_ready, 1);
      @(posedge clkout);
      @(posedge clkout);
      @(negedge clkout);
      rst_n = 1'b0; req_valid = 1'b0; #1;
      chk("rstrb_op_valid", op_valid, 0);
      chk("rstrb_op_a", op_a, 0);
      chk("rstrb_op_b", op_b, 0);
      chk("rstrb_rf_sal", rf_sal, 0);
      chk("rstrb_rf_addr", rf_addr, 0);
      chk("rstrb_rf_wdata", rf_wdata, 0);
      chk("rstrb_wb_ready", wb_ready, 1);
      @(negedge clkout); rst_n = 1'b1;
      repeat (6) @(negedge clkout);
      chk("rstrb_no_pulse", vpulse - p0, 0);
      chk("rstrb_idle_wb_ready", wb_ready, 1);

      // Fill r1..r31 back-to-back, then read pairs (k, 32-k)
      gapbad = 0; pw = 0;
      for (int k = 1; k < 32; k++) begin
         val = 32'(k) * 32'h01010101;
         do_wr(AW'(k), val, w);
         if (k > 1 && w - pw != 2) gapbad++;
         pw = w;
      end
      chk("walk_wr_gaps", gapbad, 0);
      gapbad = 0; pf = 0;
      for (int k = 1; k < 32; k++) begin
         do_rd(AW'(k), AW'(32 - k), 1'b1, a, b, f, lat);
         chk($sformatf("walk_a_r%0d", k), a, 32'(k) * 32'h01010101);
         chk($sformatf("walk_b_r%0d", 32 - k), b, 32'(32 - k) * 32'h01010101);
         if (k > 1 && f - pf != 5) gapbad++;
         pf = f;
      end
      chk("walk_rd_gaps", gapbad, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
